// File: rtl/div_iter_if.sv
// Start/result handshake between the execute stage and the iterative divider.
// The master drives the request; the slave (the divider) returns status and the packed result.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic                 en;
  logic                 cancel;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 sign;
  logic                 busy;
  logic                 data_ok;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output en, cancel, a, b, sign,
    input  busy, data_ok, result
  );

  modport slave (
    input  en, cancel, a, b, sign,
    output busy, data_ok, result
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider on operand magnitudes with sign fix-up on completion.
// Result is packed {remainder, quotient} to share the HI/LO write path with the multiplier.
module div_iter #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  div_iter_if.slave  bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic               accept, finish;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   rem, quo, dvs, a_raw;
  logic               sa, sb;
  logic [2*WIDTH-1:0] result;

  logic               a_neg, b_neg;
  logic [WIDTH:0]     rem_sh, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;

  assign a_neg = bus.sign & bus.a[WIDTH-1];
  assign b_neg = bus.sign & bus.b[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    if (bus.cancel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.en) begin
          state_nxt = BUSY;
          accept    = 1'b1;
        end
        BUSY: if (cnt == LAST) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      a_raw  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        rem   <= '0;
        quo   <= a_neg ? -bus.a : bus.a;
        dvs   <= b_neg ? -bus.b : bus.b;
        a_raw <= bus.a;
        sa    <= a_neg;
        sb    <= b_neg;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        rem <= rem_nxt;
        quo <= quo_nxt;
      end
      // Final iteration result goes straight into the fix-up; a zero divisor
      // bypasses the datapath and reports the raw dividend.
      if (finish) begin
        if (dvs == '0) result <= {a_raw, {WIDTH{1'b1}}};
        else           result <= {sa ? -rem_nxt : rem_nxt,
                                  (sa ^ sb) ? -quo_nxt : quo_nxt};
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.data_ok = (state == DONE);
  assign bus.result  = result;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed table, random vs arithmetic model,
// and hand-written handshake, cancel and reset sequences.
module tb_div_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  div_iter_if #(.WIDTH(W)) bus ();
  div_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [63:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             passed++;
  endtask

  // Plain-arithmetic reference: 64-bit division avoids the signed overflow case.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation (caller is just after a rising edge), scramble inputs
  // after acceptance, then observe 36 cycles.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] res, output int lat, output int pulses,
                       output int busy_bad);
    bus.a = a; bus.b = b; bus.sign = s; bus.en = 1'b1;
    step();
    bus.en = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.sign = 1'($urandom_range(0, 1));
    res = '0; lat = -1; pulses = 0; busy_bad = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (bus.data_ok) begin
        pulses++;
        lat = k;
        res = bus.result;
      end
      if (bus.busy !== (k <= 33)) busy_bad++;
      step();
    end
  endtask

  task automatic run_checked(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [63:0] exp);
    logic [63:0] res;
    int lat, pulses, busy_bad;
    do_op(a, b, s, res, lat, pulses, busy_bad);
    check({name, " result"}, res, exp);
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " pulses"}, 64'(pulses), 64'd1);
    check({name, " busy"}, 64'(busy_bad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[10];
    logic [63:0] res, prev;
    int lat, pulses, busy_bad, first, bad;
    int okq[$];

    vt[0] = '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, "u100/7"};
    vt[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, "s-7/2"};
    vt[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 64'h00000001_FFFFFFFD, "s7/-2"};
    vt[3] = '{32'h1234_5678,  32'd0,          1'b1, 64'h12345678_FFFFFFFF, "sdiv0"};
    vt[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h00000000_80000000, "sovf"};
    vt[5] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 64'h00000000_FFFFFFFF, "umax/1"};
    vt[6] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 64'h00000001_7FFFFFFC, "ubig/2"};
    vt[7] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 64'hFFFFFFFE_0000000E, "s-100/-7"};
    vt[8] = '{32'd5,          32'd0,          1'b0, 64'h00000005_FFFFFFFF, "udiv0"};
    vt[9] = '{32'hFFFF_FFF0,  32'd0,          1'b1, 64'hFFFFFFF0_FFFFFFFF, "sdiv0neg"};

    bus.en = 1'b0; bus.cancel = 1'b0; bus.a = '0; bus.b = '0; bus.sign = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset data_ok", 64'(bus.data_ok), 64'd0);
    check("reset result", bus.result, 64'd0);
    step();
    rst = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_checked(vt[i].name, vt[i].a, vt[i].b, vt[i].sign, vt[i].exp);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = ~32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, res, lat, pulses, busy_bad);
      check($sformatf("rand%0d %h/%h s%0d", i, ra, rb, rs), res, model(ra, rb, rs));
      check($sformatf("rand%0d latency", i), 64'(lat), 64'd33);
    end

    // en held high: accepts at 0, 34, 68; DONE cycles must not re-accept.
    bus.a = 32'd100; bus.b = 32'd7; bus.sign = 1'b0; bus.en = 1'b1;
    for (int c = 0; c <= 101; c++) begin
      @(negedge clk);
      if (bus.data_ok) okq.push_back(c);
      step();
    end
    bus.en = 1'b0;
    check("en-held pulse count", 64'(okq.size()), 64'd3);
    if (okq.size() == 3) begin
      check("en-held pulse0", 64'(okq[0]), 64'd33);
      check("en-held pulse1", 64'(okq[1]), 64'd67);
      check("en-held pulse2", 64'(okq[2]), 64'd101);
    end
    check("en-held result", bus.result, 64'h00000002_0000000E);
    step();

    // Cancel at cycle 10, restart at cycle 11, completion at 44.
    run_checked("pre-cancel", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD);
    prev = 64'h00000001_FFFFFFFD;
    bus.a = 32'd1000; bus.b = 32'd3; bus.sign = 1'b0; bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    repeat (9) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    bus.a = 32'd50; bus.b = 32'd5; bus.en = 1'b1;
    @(negedge clk);
    check("cancel busy", 64'(bus.busy), 64'd0);
    check("cancel data_ok", 64'(bus.data_ok), 64'd0);
    check("cancel result kept", bus.result, prev);
    step();
    bus.en = 1'b0;
    first = -1; pulses = 0; bad = 0;
    for (int c = 12; c <= 46; c++) begin
      @(negedge clk);
      if (bus.data_ok) begin
        pulses++;
        if (first < 0) begin
          first = c;
          res = bus.result;
        end
      end
      if (c < 44 && bus.result !== prev) bad++;
      step();
    end
    check("restart done cycle", 64'(first), 64'd44);
    check("restart pulses", 64'(pulses), 64'd1);
    check("restart result", res, 64'h00000000_0000000A);
    check("restart result stable", 64'(bad), 64'd0);

    // en and cancel together in IDLE: nothing accepted.
    bus.a = 32'd9; bus.b = 32'd3; bus.en = 1'b1; bus.cancel = 1'b1;
    step();
    bus.en = 1'b0; bus.cancel = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy || bus.data_ok) bad++;
      step();
    end
    check("en+cancel ignored", 64'(bad), 64'd0);
    check("en+cancel result", bus.result, 64'h00000000_0000000A);

    // Reset at cycle 20 of a run.
    bus.a = 32'd77; bus.b = 32'd5; bus.sign = 1'b0; bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    repeat (19) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midrun reset busy", 64'(bus.busy), 64'd0);
    check("midrun reset data_ok", 64'(bus.data_ok), 64'd0);
    check("midrun reset result", bus.result, 64'd0);
    step();
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.data_ok) bad++;
      step();
    end
    check("post-reset silent", 64'(bad), 64'd0);
    run_checked("post-reset op", 32'd77, 32'd5, 1'b0, 64'h00000002_0000000F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle iterative integer divider, the inverse companion of the pipelined multiplier in the execute stage.
- Shares the multiplier's en / data_ok handshake.
- Result is packed {remainder, quotient} so the HI/LO write path is common with multiply.
- Radix-2 restoring division on operand magnitudes, with sign fix-up on completion; signed or unsigned per operation.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH; iteration counter is clog2(WIDTH) bits.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets on the clock edge)
en  input  1  start request; accepted only in IDLE
cancel  input  1  flush (exception / pipeline kill); aborts any operation
a  input  WIDTH  dividend
b  input  WIDTH  divisor
sign  input  1  1 = signed (two's complement), 0 = unsigned
busy  output  1  high in BUSY and DONE states
data_ok  output  1  one-cycle pulse, result valid
result  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, counter=0, data_ok=0, busy=0, result=0, internal operand/partial-remainder registers=0. Reset mid-operation aborts the operation with no data_ok.
- States: IDLE, BUSY, DONE.
  - IDLE->BUSY when en & ~cancel.
  - BUSY->DONE after WIDTH iterations (counter reaches WIDTH-1).
  - DONE->IDLE unconditionally.
  - cancel==1 in any state -> IDLE at next edge; no data_ok; result keeps its prior value.
- Accept: at the accepting edge, latch sign, a, b, and the dividend/divisor sign bits (sign ? msb : 0). Also latch magnitudes (negate when the latched sign bit is 1). a, b and sign may change freely afterwards.
- en outside IDLE is ignored, including during the DONE cycle; no queueing.
- en and cancel both high in IDLE: cancel wins, request not accepted.
- Iteration (one per BUSY cycle), MSB first:
  - shift {rem, quo} left by one, bringing in the next dividend bit;
  - if rem >= |b|, rem -= |b| and set the quotient bit.
- Latency: en sampled high in IDLE at cycle 0 -> BUSY in cycles 1..WIDTH -> DONE with data_ok=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32). Next accept is possible from cycle WIDTH+2.
- Sign fix-up, applied when writing result on entry to DONE:
  - quotient negated if dividend sign XOR divisor sign;
  - remainder negated if dividend sign (remainder takes the dividend's sign).
- Unsigned mode: sign bits are forced to 0, so no fix-up.
- result register updates only on entry to DONE. It holds stable through DONE and afterwards until the next completed operation.
- Divide by zero (latched b==0): same latency; quotient = all ones, remainder = latched a (raw, no sign fix-up), in both modes.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF, sign=1): quotient=0x80000000, remainder=0. This falls out of magnitude arithmetic and must be preserved.
- data_ok is exactly (state==DONE); never high for more than one consecutive cycle.

Test Plan:
1. Unsigned: a=100, b=7, sign=0, en pulse at cycle 0 -> data_ok only in cycle 33; result={32'd2, 32'd14}; busy high in cycles 1..33.
2. Signed: a=-7 (0xFFFFFFF9), b=2, sign=1 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Repeat with a=7, b=-2 -> quotient -3, remainder +1.
3. Corners:
   - b=0, a=0x12345678, sign=1 -> result={0x12345678, 0xFFFFFFFF} at cycle 33.
   - a=0x80000000, b=0xFFFFFFFF, sign=1 -> {0, 0x80000000}.
   - Unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
4. Handshake:
   - en held high continuously -> operations accepted at cycles 0, 34, 68; data_ok at 33, 67, 101.
   - Changing a/b during BUSY does not alter the result.
5. Abort:
   - cancel at cycle 10 of a run -> IDLE at cycle 11, no data_ok; result keeps the previous value; a new en at cycle 11 completes at cycle 44.
   - en+cancel in the same IDLE cycle -> nothing accepted.
6. Reset: rst=0 at cycle 20 of a run -> next cycle state IDLE, data_ok=0, busy=0, result=0; no data_ok afterwards until a new en.
